// File: rtl/imm_ext_pkg.sv
// Shared encodings and limits for the pipelined immediate extender.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        MODE_SIGN   = 2'b00,
        MODE_ZERO   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } imm_mode_e;

    localparam int DEPTH_MAX = 4;
    localparam int CNT_W     = 16;

endpackage

// File: rtl/imm_ext_stage.sv
// One elastic register slice: loads when empty or when its entry is leaving downstream.
// Latency 1 cycle; holds valid/data unchanged while down_ready=0; flush clears valid.
module imm_ext_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    input  logic         down_ready,
    output logic         can_load,
    output logic         valid,
    output logic [W-1:0] data
);

    // An empty slot always loads, so bubbles collapse behind a stalled stage.
    assign can_load = !valid || down_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (can_load) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Four-mode immediate extender feeding a DEPTH-stage elastic pipeline; optional neg_cnt via IMM_EXT_STATS_EN.
// Latency DEPTH cycles, 1 result/cycle; out_ready=0 stalls stages back to in_ready, flush drops all entries.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int DEPTH    = 1,
    parameter int BR_SHAMT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
`ifdef IMM_EXT_STATS_EN
    ,
    output logic [CNT_W-1:0] neg_cnt
`endif
);

    if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("imm_extend_pipe: DEPTH must be in 1..DEPTH_MAX");
    end
    if (OUT_W < IN_W + BR_SHAMT) begin : g_bad_width
        $error("imm_extend_pipe: OUT_W too narrow for IN_W + BR_SHAMT");
    end

    logic [OUT_W-1:0] ext_data;

    always_comb begin
        ext_data = '0;
        case (imm_mode_e'(in_mode))
            MODE_SIGN:   ext_data = OUT_W'($signed(in_imm));
            MODE_ZERO:   ext_data = OUT_W'(in_imm);
            MODE_UPPER:  ext_data = OUT_W'(in_imm) << (OUT_W - IN_W);
            MODE_BRANCH: ext_data = OUT_W'($signed(in_imm)) << BR_SHAMT;
            default:     ext_data = '0;
        endcase
    end

    logic [DEPTH-1:0] st_valid;
    logic [DEPTH-1:0] st_can_load;
    logic [OUT_W-1:0] st_data [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             up_valid;
        logic [OUT_W-1:0] up_data;
        logic             down_ready;

        if (g == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = ext_data;
        end else begin : g_mid
            assign up_valid = st_valid[g-1];
            assign up_data  = st_data[g-1];
        end

        if (g == DEPTH - 1) begin : g_tail
            assign down_ready = out_ready;
        end else begin : g_link
            assign down_ready = st_can_load[g+1];
        end

        imm_ext_stage #(
            .W (OUT_W)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush),
            .up_valid   (up_valid),
            .up_data    (up_data),
            .down_ready (down_ready),
            .can_load   (st_can_load[g]),
            .valid      (st_valid[g]),
            .data       (st_data[g])
        );
    end

    assign in_ready  = st_can_load[0] && !flush;
    assign out_valid = st_valid[DEPTH-1];
    assign out_data  = st_data[DEPTH-1];

`ifdef IMM_EXT_STATS_EN
    // Flush cancels the output transfer, so it must not be counted that cycle.
    logic out_fire_neg;
    assign out_fire_neg = out_valid && out_ready && !flush && out_data[OUT_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_cnt <= '0;
        end else if (out_fire_neg && (neg_cnt != {CNT_W{1'b1}})) begin
            neg_cnt <= neg_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
